// File: rtl/sort_frame_loader.sv
// sort_frame_loader
//   Collects a serial stream of DATA_WIDTH-bit words into one N = 2**LOG_INPUT
//   lane frame and hands it to the bitonic sorter as a one-cycle-valid parallel
//   vector. Frames cut short by s_last or by an idle timeout are padded with
//   PAD_VALUE. The fill buffer is separate from x, so the next frame fills
//   while the previous one is still held on x.
//
// Ports
//   clk      in   rising-edge clock
//   rst      in   asynchronous active-low reset
//   s_data   in   input element
//   s_valid  in   s_data valid
//   s_last   in   final element of a frame (only meaningful with s_valid)
//   s_ready  out  loader can accept; a beat transfers on s_valid && s_ready
//   x        out  frame to sorter, lane k = bits DATA_WIDTH*(k+1)-1 : DATA_WIDTH*k
//   x_valid  out  one-cycle pulse, x holds a new frame
//   x_count  out  number of real (non-pad) lanes in x, 1..N
module sort_frame_loader #(
    parameter int unsigned            LOG_INPUT  = 4,
    parameter int unsigned            DATA_WIDTH = 8,
    parameter logic [DATA_WIDTH-1:0]  PAD_VALUE  = '1,
    parameter int unsigned            TIMEOUT    = 0
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [DATA_WIDTH-1:0]                s_data,
    input  logic                                 s_valid,
    input  logic                                 s_last,
    output logic                                 s_ready,
    output logic [DATA_WIDTH*(2**LOG_INPUT)-1:0] x,
    output logic                                 x_valid,
    output logic [LOG_INPUT:0]                   x_count
);

    localparam int unsigned    N         = 2 ** LOG_INPUT;
    localparam int unsigned    W         = DATA_WIDTH * N;
    localparam logic [W-1:0]   PAD_FRAME = {N{PAD_VALUE}};
    localparam logic [15:0]    TO_LIMIT  = 16'(TIMEOUT);

    typedef enum logic {
        ST_EMPTY,
        ST_FILLING
    } state_t;

    // control state
    state_t                 r_state;
    state_t                 w_state_next;
    logic [LOG_INPUT-1:0]   r_idx;
    logic [LOG_INPUT-1:0]   w_idx_next;
    logic [15:0]            r_idle;
    logic [15:0]            w_idle_next;

    // ready pipeline: arms on the first edge after release, ready on the second
    logic                   r_arm;
    logic                   r_ready;

    // datapath
    logic [W-1:0]           r_buf;
    logic [W-1:0]           w_buf_next;
    logic [W-1:0]           w_frame;
    logic [LOG_INPUT:0]     w_count;

    logic                   w_beat;
    logic                   w_complete;
    logic                   w_timeout;
    logic                   w_emit;
    logic [15:0]            w_idle_inc;

    assign s_ready    = r_ready;
    assign w_beat     = s_valid && r_ready;
    assign w_complete = w_beat && (s_last || (r_idx == '1));
    assign w_idle_inc = r_idle + 16'd1;
    // The flush fires on the edge that would take the counter to TIMEOUT; a
    // beat in that same cycle takes priority and the flush is dropped.
    assign w_timeout  = (TIMEOUT != 0) && (r_state == ST_FILLING) && !w_beat &&
                        (w_idle_inc == TO_LIMIT);
    assign w_emit     = w_complete || w_timeout;

    // ------------------------------------------------------------------
    // state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_EMPTY;
            r_idx   <= '0;
            r_idle  <= '0;
        end else begin
            r_state <= w_state_next;
            r_idx   <= w_idx_next;
            r_idle  <= w_idle_next;
        end
    end

    // ------------------------------------------------------------------
    // next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_idx_next   = r_idx;
        w_idle_next  = r_idle;
        if (w_emit) begin
            w_state_next = ST_EMPTY;
            w_idx_next   = '0;
            w_idle_next  = '0;
        end else if (w_beat) begin
            w_state_next = ST_FILLING;
            w_idx_next   = r_idx + LOG_INPUT'(1);
            w_idle_next  = '0;
        end else if (r_state == ST_FILLING) begin
            if (TIMEOUT != 0) begin
                w_idle_next = w_idle_inc;
            end
        end else begin
            w_idle_next = '0;
        end
    end

    // ------------------------------------------------------------------
    // output / datapath logic
    // ------------------------------------------------------------------
    always_comb begin
        w_frame    = PAD_FRAME;
        w_buf_next = r_buf;
        for (int unsigned k = 0; k < N; k++) begin
            // lanes below idx are already filled; the completing beat lands
            // at idx; everything above is pad
            if (k < 32'(r_idx)) begin
                w_frame[k*DATA_WIDTH +: DATA_WIDTH] = r_buf[k*DATA_WIDTH +: DATA_WIDTH];
            end else if ((k == 32'(r_idx)) && w_complete) begin
                w_frame[k*DATA_WIDTH +: DATA_WIDTH] = s_data;
            end else begin
                w_frame[k*DATA_WIDTH +: DATA_WIDTH] = PAD_VALUE;
            end
            if (w_beat && (k == 32'(r_idx))) begin
                w_buf_next[k*DATA_WIDTH +: DATA_WIDTH] = s_data;
            end
        end
        if (w_emit) begin
            w_buf_next = PAD_FRAME;
        end
        if (w_complete) begin
            w_count = {1'b0, r_idx} + (LOG_INPUT + 1)'(1);
        end else begin
            w_count = {1'b0, r_idx};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_arm   <= 1'b0;
            r_ready <= 1'b0;
            r_buf   <= PAD_FRAME;
            x       <= '0;
            x_valid <= 1'b0;
            x_count <= '0;
        end else begin
            r_arm   <= 1'b1;
            r_ready <= r_arm;
            r_buf   <= w_buf_next;
            x_valid <= w_emit;
            if (w_emit) begin
                x       <= w_frame;
                x_count <= w_count;
            end
        end
    end

endmodule

// File: tb/tb_sort_frame_loader.sv
module tb_sort_frame_loader;

    localparam int unsigned LOG_INPUT  = 2;
    localparam int unsigned DATA_WIDTH = 8;
    localparam int unsigned N          = 4;

    logic                         clk;
    logic                         rst;
    logic [DATA_WIDTH-1:0]        s_data;
    logic                         s_valid;
    logic                         s_last;
    logic                         s_ready;
    logic [DATA_WIDTH*N-1:0]      x;
    logic                         x_valid;
    logic [LOG_INPUT:0]           x_count;

    sort_frame_loader #(
        .LOG_INPUT (LOG_INPUT),
        .DATA_WIDTH(DATA_WIDTH),
        .PAD_VALUE (8'hFF),
        .TIMEOUT   (3)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .s_data (s_data),
        .s_valid(s_valid),
        .s_last (s_last),
        .s_ready(s_ready),
        .x      (x),
        .x_valid(x_valid),
        .x_count(x_count)
    );

    typedef struct {
        logic [31:0] fx;
        logic [2:0]  cnt;
        int          cyc;
    } exp_t;

    exp_t q[$];
    int   total   = 0;
    int   bad     = 0;
    int   cyc     = 0;
    int   pulses  = 0;
    int   pushed  = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // called right after the accepting/flushing edge reference point
    task automatic expect_frame(input logic [31:0] fx, input logic [2:0] cnt, input int offs);
        exp_t e;
        e.fx  = fx;
        e.cnt = cnt;
        e.cyc = cyc + offs;
        q.push_back(e);
        pushed++;
    endtask

    task automatic beat(input logic [7:0] d, input logic last);
        s_data  = d;
        s_valid = 1'b1;
        s_last  = last;
        chk("s_ready_on_beat", 64'(s_ready), 64'd1);
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int k;
        k = 0;
        while (!s_ready && k < 10) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk("ready_after_reset", 64'(s_ready), 64'd1);
    endtask

    // monitor: every x_valid pulse must match the oldest expected frame,
    // including the cycle it is due on
    always @(negedge clk) begin
        if (rst && x_valid) begin
            exp_t e;
            pulses++;
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_x_valid: x=%0h x_count=%0d at cycle %0d, none expected", x, x_count, cyc);
            end else begin
                e = q.pop_front();
                chk("frame_x", 64'(x), 64'(e.fx));
                chk("frame_count", 64'(x_count), 64'(e.cnt));
                chk("frame_cycle", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    initial begin
        rst     = 1'b0;
        s_valid = 1'b0;
        s_last  = 1'b0;
        s_data  = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_x", 64'(x), 64'd0);
        chk("reset_x_count", 64'(x_count), 64'd0);
        chk("reset_x_valid", 64'(x_valid), 64'd0);
        chk("reset_s_ready", 64'(s_ready), 64'd0);

        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("s_ready_first_edge", 64'(s_ready), 64'd0);
        @(posedge clk);
        #1;
        chk("s_ready_second_edge", 64'(s_ready), 64'd1);

        // full frame closed by s_last on the last lane
        beat(8'h10, 1'b0);
        beat(8'h20, 1'b0);
        beat(8'h30, 1'b0);
        beat(8'h40, 1'b1);
        expect_frame(32'h40302010, 3'd4, 0);
        idle(2);

        // eight back-to-back beats, no s_last
        for (int i = 1; i <= 8; i++) begin
            beat(8'(i), 1'b0);
            if (i == 4) expect_frame(32'h04030201, 3'd4, 0);
            if (i == 8) expect_frame(32'h08070605, 3'd4, 0);
        end
        idle(2);

        // short frame
        beat(8'hAA, 1'b0);
        beat(8'hBB, 1'b1);
        expect_frame(32'hFFFFBBAA, 3'd2, 0);
        idle(2);

        // timeout flush after three idle cycles
        beat(8'h05, 1'b0);
        expect_frame(32'hFFFFFF05, 3'd1, 3);
        idle(6);

        // beat on the third idle cycle beats the timeout
        beat(8'h05, 1'b0);
        idle(2);
        beat(8'h06, 1'b0);
        beat(8'h07, 1'b0);
        beat(8'h08, 1'b0);
        expect_frame(32'h08070605, 3'd4, 0);

        // long idle while empty: nothing may come out
        idle(100);

        // reset in the middle of a frame
        beat(8'h11, 1'b0);
        beat(8'h22, 1'b0);
        rst = 1'b0;
        idle(2);
        chk("midreset_x", 64'(x), 64'd0);
        chk("midreset_x_valid", 64'(x_valid), 64'd0);
        chk("midreset_x_count", 64'(x_count), 64'd0);
        rst = 1'b1;
        wait_ready();
        for (int i = 1; i <= 4; i++) begin
            beat(8'(i), 1'b0);
        end
        expect_frame(32'h04030201, 3'd4, 0);
        idle(10);

        chk("pulse_count", 64'(pulses), 64'(pushed));
        chk("queue_drained", 64'(q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected finish earlier");
        $fatal(1);
    end

endmodule
